// File: rtl/arbiter_pkg.sv
// ============================================================================
// Module  : arbiter_pkg
// Purpose : Shared types and widths for the AER arbiter / event readout path.
//           evt_pkt_t matches the aer_event_encoder pkt_data_o layout
//           {ts, pol, row, col} (ts in the MSBs) for the default widths.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package arbiter_pkg;

  localparam int EVT_TS_WIDTH  = 16;
  localparam int EVT_ROW_WIDTH = 5;
  localparam int EVT_COL_WIDTH = 5;

  typedef struct packed {
    logic [EVT_TS_WIDTH-1:0]  ts;
    logic                     pol;
    logic [EVT_ROW_WIDTH-1:0] row;
    logic [EVT_COL_WIDTH-1:0] col;
  } evt_pkt_t;

  localparam int EVT_PKT_WIDTH = $bits(evt_pkt_t);

endpackage

`default_nettype wire

// File: rtl/evt_fifo.sv
// ============================================================================
// Module  : evt_fifo
// Purpose : Parameterised synchronous FIFO with registered full/valid flags
//           and simultaneous push/pop (including when full).
// Ports   : clk, rst_n      - clock, asynchronous active-low reset
//           push, push_data - write request / payload (ignored when full
//                             unless a pop happens in the same cycle)
//           pop             - read request (ignored when empty)
//           pop_data        - head entry, forced to 0 while empty
//           valid           - FIFO holds at least one entry
//           full            - FIFO holds DEPTH entries
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module evt_fifo
  import arbiter_pkg::*;
#(
  parameter int WIDTH = EVT_PKT_WIDTH,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             valid,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             wr_en;
  logic             rd_en;

  // A pop in the same cycle frees the slot being written, so a full FIFO
  // can still accept a push.
  assign rd_en = pop & valid;
  assign wr_en = push & (~full | rd_en);

  always_comb begin
    count_next = count;
    case ({wr_en, rd_en})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      valid  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
      full  <= (count_next == CNT_W'(DEPTH));
      valid <= (count_next != '0);
    end
  end

  // Storage needs no reset: the read port is masked until an entry exists.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  assign pop_data = valid ? mem[rd_ptr] : '0;

endmodule

`default_nettype wire

// File: rtl/aer_event_encoder.sv
// ============================================================================
// Module  : aer_event_encoder
// Purpose : Latches arbiter grants (row, col, polarity), stamps them with a
//           free-running timestamp and queues {ts, pol, row, col} packets in
//           evt_fifo for a valid/ready readout. Events that arrive while the
//           buffer is full (and nothing drains) are dropped.
// Ports   : clk_i, reset_i        - clock, asynchronous active-low reset
//           evt_valid_i           - arbiter grant valid
//           row_addr_i/col_addr_i - granted pixel address
//           pol_i                 - event polarity (1 = ON)
//           pkt_valid_o/pkt_data_o/pkt_ready_i - readout handshake
//           fifo_full_o           - buffer full (registered)
//           drop_cnt_o            - saturating dropped-event count
// Config  : AER_DROP_CNT_EN - when defined, builds the 16-bit saturating
//           drop counter; otherwise drop_cnt_o is tied to 0.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module aer_event_encoder
  import arbiter_pkg::*;
#(
  parameter int ROW_ADDR_WIDTH = EVT_ROW_WIDTH,
  parameter int COL_ADDR_WIDTH = EVT_COL_WIDTH,
  parameter int TS_WIDTH       = EVT_TS_WIDTH,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                                             clk_i,
  input  logic                                             reset_i,
  input  logic                                             evt_valid_i,
  input  logic [ROW_ADDR_WIDTH-1:0]                        row_addr_i,
  input  logic [COL_ADDR_WIDTH-1:0]                        col_addr_i,
  input  logic                                             pol_i,
  output logic                                             pkt_valid_o,
  output logic [TS_WIDTH+1+ROW_ADDR_WIDTH+COL_ADDR_WIDTH-1:0] pkt_data_o,
  input  logic                                             pkt_ready_i,
  output logic                                             fifo_full_o,
  output logic [15:0]                                      drop_cnt_o
);

  localparam int PKT_WIDTH = TS_WIDTH + 1 + ROW_ADDR_WIDTH + COL_ADDR_WIDTH;

  logic [TS_WIDTH-1:0]  ts;
  logic                 pop;
  logic                 push;
  logic [PKT_WIDTH-1:0] pkt_in;

  // Free-running timestamp; wraps silently.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) ts <= '0;
    else          ts <= ts + TS_WIDTH'(1);
  end

  assign pop    = pkt_valid_o & pkt_ready_i;
  assign push   = evt_valid_i & (~fifo_full_o | pop);
  assign pkt_in = {ts, pol_i, row_addr_i, col_addr_i};

  evt_fifo #(
    .WIDTH (PKT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_evt_fifo (
    .clk       (clk_i),
    .rst_n     (reset_i),
    .push      (push),
    .push_data (pkt_in),
    .pop       (pop),
    .pop_data  (pkt_data_o),
    .valid     (pkt_valid_o),
    .full      (fifo_full_o)
  );

`ifdef AER_DROP_CNT_EN
  logic        drop;
  logic [15:0] drop_cnt;

  // Pixel requests cannot be stalled, so a full buffer with no drain loses
  // the event; count it, holding at all-ones.
  assign drop = evt_valid_i & fifo_full_o & ~pop;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign drop_cnt_o = drop_cnt;
`else
  assign drop_cnt_o = 16'd0;
`endif

endmodule

`default_nettype wire
